// File: rtl/sd_cmd_sequencer_if.sv
// SPI slave job interface: frame in, job programming and tx data out.
// master = command sequencer side, slave = byte-level SPI slave side.
interface sd_cmd_sequencer_if #(
    parameter int AW = 6
);
    logic [5:0][7:0] cmd;
    logic            transfer;
    logic            done;
    logic            wr;
    logic [7:0]      rx_byte;
    logic [AW-1:0]   slv_addr;
    logic            op;
    logic            start;
    logic [AW-1:0]   size;
    logic [7:0]      tx_byte;

    modport master (
        input  cmd, transfer, done, wr, rx_byte, slv_addr,
        output op, start, size, tx_byte
    );

    modport slave (
        output cmd, transfer, done, wr, rx_byte, slv_addr,
        input  op, start, size, tx_byte
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// SD command layer: decodes 6-byte frames, tracks init state,
// programs one SPI slave job per frame and moves block data.
module sd_cmd_sequencer #(
    parameter  int MEMORY_SIZE_IN_BYTES = 64,
    parameter  int BLOCK_BYTES          = 32,
    parameter  int NUM_BLOCKS           = MEMORY_SIZE_IN_BYTES / BLOCK_BYTES,
    localparam int AW                   = $clog2(MEMORY_SIZE_IN_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    sd_cmd_sequencer_if.master bus,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata,
    output logic          card_idle,
    output logic          blk_written
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_START  = 2'd2;
    localparam logic [1:0] ST_XFER   = 2'd3;

    localparam logic [1:0] K_RESP1 = 2'd0;
    localparam logic [1:0] K_R7    = 2'd1;
    localparam logic [1:0] K_RD    = 2'd2;
    localparam logic [1:0] K_WR    = 2'd3;

    localparam logic [AW-1:0] BLK_B  = AW'(BLOCK_BYTES);
    localparam logic [AW-1:0] BLK_SZ = AW'(BLOCK_BYTES + 3);
    localparam logic [AW-1:0] D_OFF  = AW'(2);
    localparam logic [AW-1:0] D_END  = AW'(BLOCK_BYTES + 1);

    logic [1:0]      state;
    logic [4:0][7:0] cmd_q;
    logic            stop_q;
    logic [1:0]      kind_q;
    logic [7:0]      r1_q;
    logic            op_q;
    logic [AW-1:0]   size_q;
    logic [AW-1:0]   base_q;
    logic            app_cmd;
    logic            tok_err;
    logic            we_q;
    logic [AW-1:0]   waddr_q;

    logic [5:0]    idx;
    logic [31:0]   arg;
    logic          ok;
    logic [7:0]    d_r1;
    logic [1:0]    d_kind;
    logic          d_op;
    logic [AW-1:0] d_size;
    logic [AW-1:0] d_base;
    logic          n_idle;
    logic          n_app;
    logic          job;
    logic          in_data;
    logic [AW-1:0] data_addr;

    assign idx = cmd_q[0][5:0];
    assign arg = {cmd_q[1], cmd_q[2], cmd_q[3], cmd_q[4]};
    assign ok  = (cmd_q[0][7:6] == 2'b01) && stop_q;

    always_comb begin
        d_r1   = {5'b0, 1'b1, 1'b0, card_idle};
        d_kind = K_RESP1;
        d_op   = 1'b1;
        d_size = '0;
        d_base = arg[AW-1:0] * BLK_B;
        n_idle = card_idle;
        n_app  = 1'b0;
        unique case (1'b1)
            !ok: ;
            ok && idx == 6'd0: begin
                n_idle = 1'b1;
                d_r1   = 8'h01;
            end
            ok && idx == 6'd8: begin
                d_r1   = {7'b0, card_idle};
                d_kind = K_R7;
                d_size = AW'(4);
            end
            ok && idx == 6'd55: begin
                d_r1  = {7'b0, card_idle};
                n_app = 1'b1;
            end
            ok && idx == 6'd41 && app_cmd: begin
                n_idle = 1'b0;
                d_r1   = 8'h00;
            end
            ok && (idx == 6'd17 || idx == 6'd24): begin
                if (card_idle) begin
                    d_r1 = 8'h05;
                end else if (arg >= 32'(NUM_BLOCKS)) begin
                    d_r1 = 8'h20;
                end else begin
                    d_r1   = 8'h00;
                    d_size = BLK_SZ;
                    d_kind = (idx == 6'd24) ? K_WR : K_RD;
                    d_op   = (idx != 6'd24);
                end
            end
            default: ;
        endcase
    end

    assign job       = (state == ST_START) || (state == ST_XFER);
    assign in_data   = (bus.slv_addr >= D_OFF) && (bus.slv_addr <= D_END);
    assign data_addr = base_q + bus.slv_addr - D_OFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            stop_q      <= 1'b0;
            kind_q      <= K_RESP1;
            r1_q        <= 8'h00;
            op_q        <= 1'b0;
            size_q      <= '0;
            base_q      <= '0;
            card_idle   <= 1'b1;
            app_cmd     <= 1'b0;
            tok_err     <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            mem_wdata   <= 8'h00;
            blk_written <= 1'b0;
        end else begin
            we_q        <= 1'b0;
            blk_written <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.transfer) begin
                        cmd_q  <= bus.cmd[4:0];
                        stop_q <= bus.cmd[5][0];
                        state  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r1_q      <= d_r1;
                    kind_q    <= d_kind;
                    op_q      <= d_op;
                    size_q    <= d_size;
                    base_q    <= d_base;
                    card_idle <= n_idle;
                    app_cmd   <= n_app;
                    tok_err   <= 1'b0;
                    state     <= ST_START;
                end
                ST_START: state <= ST_XFER;
                default: begin
                    if (bus.wr && kind_q == K_WR) begin
                        if (bus.slv_addr == AW'(1) && bus.rx_byte != 8'hFE)
                            tok_err <= 1'b1;
                        if (in_data && !tok_err) begin
                            we_q      <= 1'b1;
                            waddr_q   <= data_addr;
                            mem_wdata <= bus.rx_byte;
                        end
                    end
                    if (bus.done) begin
                        blk_written <= (kind_q == K_WR) && !tok_err;
                        state       <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Reads need a combinational address since mem_rdata is same-cycle.
    always_comb begin
        mem_addr = '0;
        if (we_q)
            mem_addr = waddr_q;
        else if (job && kind_q == K_RD)
            mem_addr = data_addr;
    end

    always_comb begin
        bus.tx_byte = 8'h00;
        if (job) begin
            unique case (kind_q)
                K_RESP1: bus.tx_byte = r1_q;
                K_R7: begin
                    if (bus.slv_addr == AW'(0))
                        bus.tx_byte = r1_q;
                    else if (bus.slv_addr == AW'(3))
                        bus.tx_byte = {4'h0, cmd_q[3][3:0]};
                    else if (bus.slv_addr == AW'(4))
                        bus.tx_byte = cmd_q[4];
                end
                K_RD: begin
                    if (bus.slv_addr == AW'(0))
                        bus.tx_byte = r1_q;
                    else if (bus.slv_addr == AW'(1))
                        bus.tx_byte = 8'hFE;
                    else if (in_data)
                        bus.tx_byte = mem_rdata;
                    else
                        bus.tx_byte = 8'hFF;
                end
                default: begin
                    if (bus.slv_addr == AW'(0))
                        bus.tx_byte = r1_q;
                    else
                        bus.tx_byte = 8'hFF;
                end
            endcase
        end
    end

    assign bus.op    = op_q;
    assign bus.size  = size_q;
    assign bus.start = (state == ST_START);
    assign mem_we    = we_q;
endmodule
